rr_arbiter4: RTL

Four-channel round-robin arbiter that generates the 2-bit select index and enable consumed by the downstream 2-to-4 decoder. It turns four independent request lines into one registered grant (`A`, `EN`), which the decoder expands into a one-hot grant vector `Y`. Grant tenure ends on a `done` handshake, on request withdrawal or, optionally, on a cycle-count timeout. A rotating priority pointer guarantees fairness.

---
 rtl/rr_arbiter4.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-channel round-robin arbiter producing a registered index/enable pair for a 2-to-4 decoder.
// Optional grant timeout is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] A,
    output logic       EN,
    output logic       tmo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] a_q, a_d;
    logic       en_q, en_d;
    logic       tmo_q, tmo_d;
    logic [2:0] win_s;
    logic       release_s;
    logic       timeout_s;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Returns {found, index} of the first requester at or after the pointer, wrapping mod 4.
    function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] k;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) begin
                res = {1'b1, k};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign win_s = pick_winner(req, ptr_q);

`ifdef RR_ARB_TIMEOUT_EN
    assign timeout_s = (cnt_q == CNT_MAX);
`else
    assign timeout_s = 1'b0;
`endif

    assign release_s = done | ~req[a_q] | timeout_s;

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        en_d    = en_q;
        tmo_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_s[2]) begin
                    a_d     = win_s[1:0];
                    en_d    = 1'b1;
                    state_d = S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    en_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (release_s) begin
                    en_d    = 1'b0;
                    ptr_d   = a_q + 2'd1;
                    state_d = S_GAP;
                    // Timeout is only reported when neither done nor withdrawal also ended tenure.
                    tmo_d   = timeout_s & ~done & req[a_q];
                end else begin
                    en_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
`endif
                end
            end
            S_GAP: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            a_q     <= 2'd0;
            en_q    <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            en_q    <= en_d;
            tmo_q   <= tmo_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign A   = a_q;
    assign EN  = en_q;
    assign tmo = tmo_q;

endmodule
